regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the 8×16 register file between several writeback sources, such as the ALU result, the load unit and the input port. Each source raises a request carrying a register address and data. The arbiter grants at most one write per cycle and drives the register file's write enable, write address and write data from a registered output stage. It also keeps a saturating count of completed writes for debug display.

## Interface
Parameters:
- N_REQ, 3, number of requesters (2..8)
- ADDR_W, 3, register address width
- DATA_W, 16, register data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  N_REQ  request from source i, held high until its ack
- req_addr  in  N_REQ*ADDR_W  packed destination addresses; source i at bits [i*ADDR_W +: ADDR_W]
- req_data  in  N_REQ*DATA_W  packed write data; source i at bits [i*DATA_W +: DATA_W]
- ack  out  N_REQ  one-hot, one-cycle pulse: source i's write is being performed
- rf_write  out  1  write enable to the register file
- rf_addr  out  ADDR_W  register file write address
- rf_data  out  DATA_W  register file write data
- busy  out  1  high when `rf_write` is high or any `req` bit is high
- wr_count  out  16  number of writes performed, saturating at 16'hFFFF

## Operation
Handshake:
- A source asserts `req[i]` and holds `req_addr`/`req_data` stable until it samples `ack[i]`=1.
- It may drop `req[i]` or present a new request at the following edge.

Eligibility:
- A source is eligible in a cycle when `req[i]`=1 and `ack[i]`=0.
- A source being acked this cycle is masked, so the same request is never granted twice.

Arbitration (rotating pointer `ptr`, 0..N_REQ-1):
- Search eligible sources starting at `ptr` and wrapping: ptr, ptr+1, …, N_REQ-1, 0, ….
- The first eligible source wins.
- On a grant to source w: `ptr` ← (w+1) mod N_REQ.
- With no eligible source, `ptr` is unchanged.

Output stage, updated at the edge ending the arbitration cycle:
- `rf_write`=1, `rf_addr`=req_addr[w], `rf_data`=req_data[w], `ack`=one-hot(w).
- With no winner: `rf_write`=0 and `ack`=0. `rf_addr`/`rf_data` hold their last values.

Counter and status:
- `wr_count` increments by 1 on each cycle with `rf_write`=1, unless it is already 16'hFFFF.
- `busy` is combinational.

There is no FSM beyond `ptr` and the output registers. Every cycle is an arbitration cycle.

## Timing
Reset values:
- `ptr`=0, `ack`=0, `rf_write`=0, `rf_addr`=0, `rf_data`=0, `wr_count`=0.
- `busy` reflects `req` during reset.

Latency:
- A request eligible in cycle T produces `rf_write`/`ack` in cycle T+1.
- The register file captures the data at the end of T+1.

Throughput:
- One write per cycle when two or more sources keep requesting.
- A single source alone writes at most every 2 cycles, because of the ack masking.

Fairness:
- A continuously requesting source waits at most N_REQ-1 grants.

Boundary cases:
- Simultaneous requests: resolved by `ptr` only; no fixed priority.
- `ptr` wrap: a grant to N_REQ-1 sets `ptr`=0.
- Same destination address from two sources: both are performed, in grant order. The later write wins in the register file.
- Reset asserted mid-transfer: outputs clear immediately and the in-flight write is lost. Any `ack` not yet seen is dropped. Sources still holding `req` are re-arbitrated from `ptr`=0 after reset release; the first grant occurs in the first cycle after release.
- `req` dropped before `ack`: protocol violation. The request is simply no longer eligible, and no ack is issued for it.

## Configuration
Macro: RF_ZERO_REG_EN.
- Defined: register 0 reads as zero.
  - A granted request with destination 0 still gets its `ack` pulse and still advances `ptr`.
  - `rf_write` stays 0 for it, and `wr_count` does not increment.
  - The write slot is wasted, not reused that cycle.
- Undefined: address 0 is an ordinary register and is treated like any other address.

## Test plan
- Reset, then `req`=3'b001, addr 2, data 16'h1234 → next cycle `rf_write`=1, `rf_addr`=2, `rf_data`=16'h1234, `ack`=3'b001. `wr_count`=1 after that edge.
- All three `req` held high for 6 cycles from reset → `ack` sequence 001, 010, 100, 001, 010, 100 with no idle cycle. `wr_count`=6.
- Source 0 alone with continuous back-to-back requests → `ack[0]` high every other cycle. `rf_write` toggles 1,0,1,0.
- Sources 1 and 2 both target addr 5 with data 16'hAAAA and 16'hBBBB, `ptr`=1 → writes in order AAAA then BBBB.
- Reset pulsed while `rf_write`=1 → `rf_write`, `ack` and `wr_count` are 0 during reset. After release, a held `req`=3'b100 is granted one cycle later.
- With RF_ZERO_REG_EN defined: a request to addr 0 → `ack` pulses, `rf_write`=0, `wr_count` unchanged. Without the macro: the same request gives `rf_write`=1 and `wr_count`+1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the shared register-file write port. The outputs are registered.
// Define RF_ZERO_REG_EN to make register 0 read-only zero: its grants are acked but never written.
module regfile_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        ack,
    output logic                    rf_write,
    output logic [ADDR_W-1:0]       rf_addr,
    output logic [DATA_W-1:0]       rf_data,
    output logic                    busy,
    output logic [15:0]             wr_count
);
    localparam int               PTR_W = $clog2(N_REQ);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0]  r_ptr;
    logic [N_REQ-1:0]  r_ack;
    logic              r_rf_write;
    logic [ADDR_W-1:0] r_rf_addr;
    logic [DATA_W-1:0] r_rf_data;
    logic [15:0]       r_wr_count;

    logic [N_REQ-1:0]  w_elig;
    logic              w_found;
    logic [PTR_W-1:0]  w_win;
    logic [PTR_W-1:0]  w_idx;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [N_REQ-1:0]  w_ack_nxt;
    logic              w_wr_en;

    // Scanning from the far end lets the candidate closest to r_ptr overwrite the others.
    always_comb begin
        w_elig  = req & ~r_ack;
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PTR_W'((int'(r_ptr) + k) % N_REQ);
            if (w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_addr    = '0;
        w_data    = '0;
        w_ack_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_addr       = req_addr[i*ADDR_W +: ADDR_W];
                w_data       = req_data[i*DATA_W +: DATA_W];
                w_ack_nxt[i] = w_found;
            end
        end
        w_ptr_nxt = (w_win == LAST) ? '0 : w_win + 1'b1;
`ifdef RF_ZERO_REG_EN
        w_wr_en = w_found && (w_addr != '0);
`else
        w_wr_en = w_found;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ptr      <= '0;
            r_ack      <= '0;
            r_rf_write <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_data  <= '0;
            r_wr_count <= '0;
        end else begin
            r_ack      <= w_ack_nxt;
            r_rf_write <= w_wr_en;
            if (w_found) begin
                r_ptr <= w_ptr_nxt;
            end
            if (w_wr_en) begin
                r_rf_addr <= w_addr;
                r_rf_data <= w_data;
            end
            if (w_wr_en && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign ack      = r_ack;
    assign rf_write = r_rf_write;
    assign rf_addr  = r_rf_addr;
    assign rf_data  = r_rf_data;
    assign wr_count = r_wr_count;
    assign busy     = r_rf_write | (|req);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios followed by randomized sources.
module tb_regfile_write_arbiter;
    localparam int N  = 3;
    localparam int AW = 3;
    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]  ack;
    logic          rf_write;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic [15:0]   wr_count;

    regfile_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
        .ack(ack), .rf_write(rf_write), .rf_addr(rf_addr), .rf_data(rf_data),
        .busy(busy), .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [N-1:0]  ack;
        logic [15:0]   cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: rotating pointer, last grant, write count, last written address/data.
    int            m_ptr;
    logic [N-1:0]  m_ack;
    int            m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_ack = '0; m_cnt = 0; m_addr = '0; m_data = '0;
        q.delete();
    endtask

    // One arbitration cycle computed from the current request inputs.
    task automatic model_step();
        exp_t e;
        int   w;
        logic zero;
        w = -1;
        for (int k = 0; k < N; k++) begin
            int s;
            s = (m_ptr + k) % N;
            if (w < 0 && req[s] && !m_ack[s]) w = s;
        end
        e.ack = '0;
        e.wr  = 1'b0;
        if (w >= 0) begin
            e.ack[w] = 1'b1;
            m_ptr    = (w + 1) % N;
`ifdef RF_ZERO_REG_EN
            zero = (req_addr[w*AW +: AW] == '0);
`else
            zero = 1'b0;
`endif
            if (!zero) begin
                e.wr   = 1'b1;
                m_addr = req_addr[w*AW +: AW];
                m_data = req_data[w*DW +: DW];
                if (m_cnt < 65535) m_cnt++;
            end
        end
        e.addr = m_addr;
        e.data = m_data;
        e.cnt  = m_cnt[15:0];
        m_ack  = e.ack;
        q.push_back(e);
    endtask

    // Monitor: compares each registered output set one step after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (!reset && q.size() > 0) begin
                e = q.pop_front();
                chk("ack", ack, e.ack);
                chk("rf_write", rf_write, e.wr);
                chk("rf_addr", rf_addr, e.addr);
                chk("rf_data", rf_data, e.data);
                chk("wr_count", wr_count, e.cnt);
                chk("busy", busy, e.wr | (|req));
            end
        end
    end

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic new_src(input int i);
        req[i] = 1'b1;
        set_src(i, AW'($urandom_range(0, 7)), DW'($urandom));
    endtask

    task automatic step();
        model_step();
        @(negedge clock);
    endtask

    task automatic cyc(input logic [N-1:0] r);
        req = r;
        step();
    endtask

    // Called at a negedge; returns at the negedge where reset is released.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        chk("rst_ack", ack, '0);
        chk("rst_rf_write", rf_write, 1'b0);
        chk("rst_wr_count", wr_count, 16'd0);
        chk("rst_rf_addr", rf_addr, '0);
        chk("rst_rf_data", rf_data, '0);
        chk("rst_busy", busy, |req);
        model_reset();
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        do_reset(2);

        // Single request from source 0
        set_src(0, 3'd2, 16'h1234);
        cyc(3'b001); cyc(3'b000); cyc(3'b000);

        // All three sources continuously requesting
        do_reset(1);
        set_src(0, 3'd1, 16'h0101); set_src(1, 3'd3, 16'h0303); set_src(2, 3'd4, 16'h0404);
        repeat (6) cyc(3'b111);
        cyc(3'b000); cyc(3'b000);

        // Lone source back-to-back
        do_reset(1);
        repeat (6) cyc(3'b001);
        cyc(3'b000);

        // Two sources to the same address, ptr at 1
        do_reset(1);
        set_src(0, 3'd1, 16'h1111);
        cyc(3'b001); cyc(3'b000);
        set_src(1, 3'd5, 16'hAAAA); set_src(2, 3'd5, 16'hBBBB);
        cyc(3'b110); cyc(3'b100); cyc(3'b000); cyc(3'b000);

        // Reset while a write is in flight, request held through reset
        do_reset(1);
        set_src(2, 3'd3, 16'h5555);
        cyc(3'b100);
        chk("inflight_rf_write", rf_write, 1'b1);
        do_reset(2);
        cyc(3'b100); cyc(3'b000); cyc(3'b000);

        // Destination register 0
        set_src(1, 3'd0, 16'h7777);
        cyc(3'b010); cyc(3'b000); cyc(3'b000);

        // Randomized sources following the handshake
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && ack[i]) begin
                    if ($urandom_range(0, 3) != 0) new_src(i);
                    else req[i] = 1'b0;
                end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                    new_src(i);
                end
            end
            step();
            if ($urandom_range(0, 499) == 0) do_reset(1);
        end

        cyc(3'b000); cyc(3'b000);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
